// File: rtl/nn_layer_sequencer_if.sv
// Control bus between the layer sequencer and the NN datapath.
// The master side is the sequencer. The slave side is the datapath or top-level controller.
interface nn_layer_sequencer_if #(
  parameter int N_IN    = 8,
  parameter int N_NEU   = 4,
  parameter int N_LAYER = 2
);
  localparam int WI = (N_IN    > 1) ? $clog2(N_IN)    : 1;
  localparam int WN = (N_NEU   > 1) ? $clog2(N_NEU)   : 1;
  localparam int WL = (N_LAYER > 1) ? $clog2(N_LAYER) : 1;

  logic          start;
  logic          in_valid;
  logic [WI-1:0] offset;
  logic [WN-1:0] neuron;
  logic [WL-1:0] layer;
  logic          read;
  logic          ld;
  logic          clr_acc;
  logic          wr_out;
  logic          busy;
  logic          ready;

  modport master (
    input  start, in_valid,
    output offset, neuron, layer, read, ld, clr_acc, wr_out, busy, ready
  );

  modport slave (
    output start, in_valid,
    input  offset, neuron, layer, read, ld, clr_acc, wr_out, busy, ready
  );
endinterface

// File: rtl/nn_layer_sequencer.sv
// Multi-layer MAC sequencer: walks layer/neuron/input indices and drives Moore strobes.
// It waits in READ until the datapath marks the fetched data valid.
module nn_layer_sequencer #(
  parameter int N_IN    = 8,
  parameter int N_NEU   = 4,
  parameter int N_LAYER = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  nn_layer_sequencer_if.master  bus
);
  localparam int WI = (N_IN    > 1) ? $clog2(N_IN)    : 1;
  localparam int WN = (N_NEU   > 1) ? $clog2(N_NEU)   : 1;
  localparam int WL = (N_LAYER > 1) ? $clog2(N_LAYER) : 1;

  localparam logic [WI-1:0] LAST_IN    = WI'(N_IN - 1);
  localparam logic [WN-1:0] LAST_NEU   = WN'(N_NEU - 1);
  localparam logic [WL-1:0] LAST_LAYER = WL'(N_LAYER - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_READ, S_CALC, S_STORE, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [WI-1:0] offset_q;
  logic [WN-1:0] neuron_q;
  logic [WL-1:0] layer_q;
  logic          last_in, last_neu, last_layer;

  assign last_in    = (offset_q == LAST_IN);
  assign last_neu   = (neuron_q == LAST_NEU);
  assign last_layer = (layer_q  == LAST_LAYER);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_READ;
      S_READ:  if (bus.in_valid) state_nxt = S_CALC;
      S_CALC:  state_nxt = last_in ? S_STORE : S_READ;
      S_STORE: state_nxt = (last_neu && last_layer) ? S_DONE : S_CLEAR;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The counters are zeroed in IDLE and DONE, so a run always starts from {0,0,0}.
  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE || state == S_DONE) begin
      offset_q <= '0;
      neuron_q <= '0;
      layer_q  <= '0;
    end else if (state == S_CALC) begin
      offset_q <= last_in ? '0 : offset_q + WI'(1);
    end else if (state == S_STORE) begin
      if (!last_neu) begin
        neuron_q <= neuron_q + WN'(1);
      end else if (!last_layer) begin
        neuron_q <= '0;
        layer_q  <= layer_q + WL'(1);
      end
    end
  end

  assign bus.offset  = offset_q;
  assign bus.neuron  = neuron_q;
  assign bus.layer   = layer_q;
  assign bus.clr_acc = (state == S_CLEAR);
  assign bus.read    = (state == S_READ);
  assign bus.ld      = (state == S_CALC);
  assign bus.wr_out  = (state == S_STORE);
  assign bus.ready   = (state == S_DONE);
  assign bus.busy    = (state != S_IDLE);
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Scoreboard bench for nn_layer_sequencer. Three instances are used: the defaults, 3/3/2 and 1/1/1.
module tb_nn_layer_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nn_layer_sequencer_if #(.N_IN(8), .N_NEU(4), .N_LAYER(2)) ia ();
  nn_layer_sequencer_if #(.N_IN(3), .N_NEU(3), .N_LAYER(2)) ib ();
  nn_layer_sequencer_if #(.N_IN(1), .N_NEU(1), .N_LAYER(1)) ic ();

  nn_layer_sequencer #(.N_IN(8), .N_NEU(4), .N_LAYER(2)) u_a (.clk(clk), .rst(rst), .bus(ia));
  nn_layer_sequencer #(.N_IN(3), .N_NEU(3), .N_LAYER(2)) u_b (.clk(clk), .rst(rst), .bus(ib));
  nn_layer_sequencer #(.N_IN(1), .N_NEU(1), .N_LAYER(1)) u_c (.clk(clk), .rst(rst), .bus(ic));

  int n_chk  = 0;
  int n_fail = 0;

  int         q_rdy_a[$], q_rdy_b[$], q_rdy_c[$];
  int         q_wr_b[$], q_off_b[$];
  logic [4:0] q_seq_c[$];
  int         cnt_ld_a, cnt_wr_a, cnt_clr_a;
  bit         rd_ok_a;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (ia.ready) begin
        if (q_rdy_a.size() == 0) chk("ready_a_unexpected", 1, 0);
        else                     chk("ready_a_cycle", cyc, q_rdy_a.pop_front());
      end
      if (ia.ld) begin
        cnt_ld_a++;
        chk("ld_a_needs_valid_read", rd_ok_a, 1);
      end
      if (ia.wr_out)  cnt_wr_a++;
      if (ia.clr_acc) cnt_clr_a++;
      rd_ok_a = ia.read && ia.in_valid;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (ib.ready) begin
        if (q_rdy_b.size() == 0) chk("ready_b_unexpected", 1, 0);
        else                     chk("ready_b_cycle", cyc, q_rdy_b.pop_front());
      end
      if (ib.wr_out) begin
        if (q_wr_b.size() == 0) chk("wr_b_unexpected", 1, 0);
        else chk("wr_b_layer_neuron", int'(ib.layer) * 16 + int'(ib.neuron), q_wr_b.pop_front());
      end
      if (ib.ld) begin
        if (q_off_b.size() == 0) chk("ld_b_unexpected", 1, 0);
        else                     chk("ld_b_offset", ib.offset, q_off_b.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (ic.ready) begin
        if (q_rdy_c.size() == 0) chk("ready_c_unexpected", 1, 0);
        else                     chk("ready_c_cycle", cyc, q_rdy_c.pop_front());
      end
      if (ic.busy) begin
        if (q_seq_c.size() == 0) chk("seq_c_unexpected", 1, 0);
        else chk("seq_c_strobes", {ic.clr_acc, ic.read, ic.ld, ic.wr_out, ic.ready},
                 q_seq_c.pop_front());
        chk("idx_c_zero", {ic.offset, ic.neuron, ic.layer}, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Mode 0 is plain. Mode 1 holds in_valid low for 3 cycles at each neuron's first READ.
  // Mode 2 pulses start in CLEAR, CALC and DONE. Mode 3 holds start from DONE on.
  task automatic run_a(input int mode, input int total);
    int waits = 0;
    int guard = 0;
    cnt_ld_a = 0; cnt_wr_a = 0; cnt_clr_a = 0;
    ia.start = 1'b1;
    q_rdy_a.push_back(cyc + 1 + total);
    tick();
    ia.start = 1'b0;
    chk("busy_a_after_start", ia.busy, 1);
    while (ia.busy && guard < 2000) begin
      if (mode == 1) begin
        if (ia.clr_acc) waits = 0;
        if (ia.read && ia.offset == 0 && waits < 3) begin
          ia.in_valid = 1'b0;
          waits++;
        end else ia.in_valid = 1'b1;
      end
      if (mode == 2) ia.start = ia.clr_acc || (ia.ld && ia.neuron == 1) || ia.ready;
      if (mode == 3) ia.start = ia.ready;
      tick();
      guard++;
    end
    chk("run_a_timeout", guard < 2000, 1);
    if (mode != 3) ia.start = 1'b0;
    ia.in_valid = 1'b1;
    chk("ld_a_count", cnt_ld_a, 64);
    chk("wr_a_count", cnt_wr_a, 8);
    chk("clr_a_count", cnt_clr_a, 8);
    chk("ready_a_drained", q_rdy_a.size(), 0);
  endtask

  localparam int B_WR[6] = '{'h00, 'h01, 'h02, 'h10, 'h11, 'h12};

  initial begin
    int guard;
    ia.start = 0; ia.in_valid = 1;
    ib.start = 0; ib.in_valid = 1;
    ic.start = 0; ic.in_valid = 1;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_busy", ia.busy, 0);
    chk("rst_idx", {ia.offset, ia.neuron, ia.layer}, 0);
    chk("rst_strobes", {ia.read, ia.ld, ia.clr_acc, ia.wr_out, ia.ready}, 0);
    rst = 1'b0;
    tick();

    // Reset while in READ at layer 1, neuron 2
    ia.start = 1'b1;
    tick();
    ia.start = 1'b0;
    guard = 0;
    while (!(ia.read && ia.layer == 1 && ia.neuron == 2) && guard < 2000) begin
      tick();
      guard++;
    end
    chk("reach_mid_read", guard < 2000, 1);
    chk("mid_busy_before_rst", ia.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", ia.busy, 0);
    chk("mid_rst_idx", {ia.offset, ia.neuron, ia.layer}, 0);
    chk("mid_rst_strobes", {ia.read, ia.ld, ia.clr_acc, ia.wr_out, ia.ready}, 0);
    tick();
    chk("mid_rst_stays_idle", ia.busy, 0);

    run_a(0, 144);            // ready at E+145
    tick();
    run_a(1, 168);            // ready at E+169 with backpressure
    tick();
    run_a(2, 144);            // start pulses while busy are ignored
    repeat (3) begin
      chk("no_restart_after_pulses", ia.busy, 0);
      tick();
    end
    run_a(3, 144);            // start held through DONE into IDLE
    run_a(0, 144);            // the held start launches this run
    tick();

    // Index order on 3/3/2
    foreach (B_WR[i]) q_wr_b.push_back(B_WR[i]);
    repeat (6) for (int k = 0; k < 3; k++) q_off_b.push_back(k);
    ib.start = 1'b1;
    q_rdy_b.push_back(cyc + 1 + 48);
    tick();
    ib.start = 1'b0;
    guard = 0;
    while (ib.busy && guard < 500) begin tick(); guard++; end
    chk("run_b_timeout", guard < 500, 1);
    chk("wr_b_drained", q_wr_b.size(), 0);
    chk("off_b_drained", q_off_b.size(), 0);
    chk("ready_b_drained", q_rdy_b.size(), 0);

    // 1/1/1: CLEAR, READ, CALC, STORE, DONE
    q_seq_c.push_back(5'b10000);
    q_seq_c.push_back(5'b01000);
    q_seq_c.push_back(5'b00100);
    q_seq_c.push_back(5'b00010);
    q_seq_c.push_back(5'b00001);
    ic.start = 1'b1;
    q_rdy_c.push_back(cyc + 1 + 4);
    tick();
    ic.start = 1'b0;
    guard = 0;
    while (ic.busy && guard < 100) begin tick(); guard++; end
    chk("run_c_timeout", guard < 100, 1);
    chk("seq_c_drained", q_seq_c.size(), 0);
    chk("ready_c_drained", q_rdy_c.size(), 0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
